// File: rtl/bp_update_sched.sv
// bp_update_sched: buffers resolved branches from execute and schedules them
// onto the branch predictor's single BHT port, which fetch also uses. Updates
// drain in cycles where fetch leaves the port idle. A starvation counter forces
// one drain, stalling fetch for a cycle, when lookups have blocked a pending
// update for STARVE_MAX consecutive cycles.
// Optional feature macro: BP_UPD_COALESCE_EN. When it is defined, an update
// whose index PC matches the tail entry overwrites that entry instead of
// taking a new slot.
module bp_update_sched #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                   clk,
    input  logic                   n_reset,
    input  logic                   flush,
    input  logic                   ex_valid,
    input  logic                   ex_mispred,
    input  logic [47:0]            ex_index_pc,
    input  logic [47:0]            ex_correct_pc,
    output logic                   ex_ready,
    input  logic                   fetch_req,
    output logic                   fetch_stall,
    output logic                   upd_valid,
    output logic                   upd_mispred,
    output logic [47:0]            upd_index_pc,
    output logic [47:0]            upd_correct_pc,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_PEND  = 2'b01,
        ST_FORCE = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;

    logic          mispred_q [DEPTH];
    logic [47:0]   index_q   [DEPTH];
    logic [47:0]   correct_q [DEPTH];

    logic          issue_s;
    logic          accept_s;
    logic          match_s;
    logic          wr_en_s;
    logic [PW-1:0] wr_ptr_s;

    // Port arbitration, slot availability and tail-match detection.
    always_comb begin
        issue_s  = (state_q != ST_EMPTY) && (!fetch_req || (state_q == ST_FORCE));
`ifdef BP_UPD_COALESCE_EN
        // The tail may not be merged into while it is also the head leaving this cycle.
        match_s  = (count_q != CW'(0)) &&
                   (index_q[tail_q - PW'(1)] == ex_index_pc) &&
                   !((count_q == CW'(1)) && issue_s);
`else
        match_s  = 1'b0;
`endif
        ex_ready = (count_q < CNT_FULL) || match_s;
        accept_s = ex_valid && ex_ready;
    end

    // FIFO pointer, occupancy and starvation-counter next state.
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        starve_d = starve_q;
        wr_en_s  = 1'b0;
        wr_ptr_s = tail_q;
        if (flush) begin
            // The mispredict that causes the flush must still reach the BHT.
            head_d   = PW'(0);
            starve_d = SW'(0);
            if (accept_s && ex_mispred) begin
                wr_en_s  = 1'b1;
                wr_ptr_s = PW'(0);
                tail_d   = PW'(1);
                count_d  = CW'(1);
            end else begin
                tail_d   = PW'(0);
                count_d  = CW'(0);
            end
        end else begin
            if (accept_s && match_s) begin
                wr_en_s  = 1'b1;
                wr_ptr_s = tail_q - PW'(1);
            end else if (accept_s) begin
                wr_en_s  = 1'b1;
                wr_ptr_s = tail_q;
                tail_d   = tail_q + PW'(1);
            end else begin
                wr_en_s  = 1'b0;
            end
            if (issue_s) begin
                head_d = head_q + PW'(1);
            end else begin
                head_d = head_q;
            end
            count_d = count_q
                    + ((accept_s && !match_s) ? CW'(1) : CW'(0))
                    - (issue_s ? CW'(1) : CW'(0));
            if (issue_s || (count_q == CW'(0))) begin
                starve_d = SW'(0);
            end else if (starve_q != STARVE_TOP) begin
                starve_d = starve_q + SW'(1);
            end else begin
                starve_d = starve_q;
            end
        end
    end

    // Scheduler state transitions, evaluated on next-cycle occupancy and starvation.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (count_d != CW'(0)) begin
                    state_d = ST_PEND;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_PEND: begin
                if (count_d == CW'(0)) begin
                    state_d = ST_EMPTY;
                end else if (starve_d == STARVE_TOP) begin
                    state_d = ST_FORCE;
                end else begin
                    state_d = ST_PEND;
                end
            end
            ST_FORCE: begin
                if (count_d == CW'(0)) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_PEND;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q  <= ST_EMPTY;
            head_q   <= PW'(0);
            tail_q   <= PW'(0);
            count_q  <= CW'(0);
            starve_q <= SW'(0);
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            starve_q <= starve_d;
        end
    end

    // Entry storage; cleared on reset so the head outputs read zero.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mispred_q[i] <= 1'b0;
                index_q[i]   <= 48'h0;
                correct_q[i] <= 48'h0;
            end
        end else if (wr_en_s) begin
            mispred_q[wr_ptr_s] <= ex_mispred;
            index_q[wr_ptr_s]   <= ex_index_pc;
            correct_q[wr_ptr_s] <= ex_correct_pc;
        end
    end

    assign upd_valid      = issue_s;
    assign fetch_stall    = issue_s && fetch_req;
    assign upd_mispred    = mispred_q[head_q];
    assign upd_index_pc   = index_q[head_q];
    assign upd_correct_pc = correct_q[head_q];
    assign count          = count_q;

endmodule

// File: tb/tb_bp_update_sched.sv
// Self-checking bench for bp_update_sched: directed scenarios followed by a
// randomized run against a queue-based reference model.
module tb_bp_update_sched;
    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;

    logic        clk = 1'b0;
    logic        n_reset = 1'b1;
    logic        flush = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_mispred = 1'b0;
    logic [47:0] ex_index_pc = 48'h0;
    logic [47:0] ex_correct_pc = 48'h0;
    logic        ex_ready;
    logic        fetch_req = 1'b0;
    logic        fetch_stall;
    logic        upd_valid;
    logic        upd_mispred;
    logic [47:0] upd_index_pc;
    logic [47:0] upd_correct_pc;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        m;
        logic [47:0] idx;
        logic [47:0] cpc;
    } ent_t;

    bp_update_sched #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .n_reset(n_reset), .flush(flush),
        .ex_valid(ex_valid), .ex_mispred(ex_mispred),
        .ex_index_pc(ex_index_pc), .ex_correct_pc(ex_correct_pc),
        .ex_ready(ex_ready), .fetch_req(fetch_req), .fetch_stall(fetch_stall),
        .upd_valid(upd_valid), .upd_mispred(upd_mispred),
        .upd_index_pc(upd_index_pc), .upd_correct_pc(upd_correct_pc),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic m, input logic [47:0] pc,
                         input logic [47:0] cpc, input logic fr, input logic fl);
        @(negedge clk);
        ex_valid = v; ex_mispred = m; ex_index_pc = pc; ex_correct_pc = cpc;
        fetch_req = fr; flush = fl;
        #1;
    endtask

    task automatic do_reset();
        #1;
        n_reset = 1'b0;
        ex_valid = 1'b0; ex_mispred = 1'b0; ex_index_pc = 48'h0; ex_correct_pc = 48'h0;
        fetch_req = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        n_reset = 1'b0;
        #1;
        checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset_ex_ready got %b want 1", ex_ready); end
        checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL reset_fetch_stall got %b want 0", fetch_stall); end
        checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL reset_upd_valid got %b want 0", upd_valid); end
        checks++; if (upd_mispred !== 1'b0) begin errors++; $display("FAIL reset_upd_mispred got %b want 0", upd_mispred); end
        checks++; if (upd_index_pc !== 48'h0) begin errors++; $display("FAIL reset_upd_index_pc got %h want 0", upd_index_pc); end
        checks++; if (upd_correct_pc !== 48'h0) begin errors++; $display("FAIL reset_upd_correct_pc got %h want 0", upd_correct_pc); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        @(negedge clk);
        n_reset = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        drive(1'b1, 1'b1, 48'h1000, 48'h2000, 1'b0, 1'b0);
        checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass got %b want 0", upd_valid); end
        drive(1'b0, 1'b0, 48'h0, 48'h0, 1'b0, 1'b0);
        checks++; if (upd_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", upd_valid); end
        checks++; if (upd_mispred !== 1'b1) begin errors++; $display("FAIL single_mispred got %b want 1", upd_mispred); end
        checks++; if (upd_index_pc !== 48'h1000) begin errors++; $display("FAIL single_index got %h want 1000", upd_index_pc); end
        checks++; if (upd_correct_pc !== 48'h2000) begin errors++; $display("FAIL single_correct got %h want 2000", upd_correct_pc); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count1 got %0d want 1", count); end
        drive(1'b0, 1'b0, 48'h0, 48'h0, 1'b0, 1'b0);
        checks++; if (count !== 3'd0 || upd_valid !== 1'b0) begin errors++; $display("FAIL single_drained count %0d valid %b want 0 0", count, upd_valid); end
    endtask

    task automatic test_starve();
        do_reset();
        drive(1'b1, 1'b0, 48'h1111, 48'h2222, 1'b1, 1'b0);
        for (int i = 0; i < STARVE_MAX; i++) begin
            drive(1'b0, 1'b0, 48'h0, 48'h0, 1'b1, 1'b0);
            checks++; if (upd_valid !== 1'b0 || fetch_stall !== 1'b0) begin errors++; $display("FAIL starve_blocked cycle %0d valid %b stall %b want 0 0", i, upd_valid, fetch_stall); end
        end
        drive(1'b0, 1'b0, 48'h0, 48'h0, 1'b1, 1'b0);
        checks++; if (upd_valid !== 1'b1 || fetch_stall !== 1'b1) begin errors++; $display("FAIL starve_force valid %b stall %b want 1 1", upd_valid, fetch_stall); end
        checks++; if (upd_index_pc !== 48'h1111) begin errors++; $display("FAIL starve_force_index got %h want 1111", upd_index_pc); end
        drive(1'b0, 1'b0, 48'h0, 48'h0, 1'b1, 1'b0);
        checks++; if (upd_valid !== 1'b0 || fetch_stall !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL starve_after valid %b stall %b count %0d want 0 0 0", upd_valid, fetch_stall, count); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, 48'hA000 + 48'(i), 48'hB000 + 48'(i), 1'b1, 1'b0);
        drive(1'b1, 1'b1, 48'hDEAD, 48'hBEEF, 1'b1, 1'b0);
        checks++; if (ex_ready !== 1'b0 || count !== 3'd4) begin errors++; $display("FAIL full_ready ready %b count %0d want 0 4", ex_ready, count); end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b0, 48'h0, 48'h0, 1'b0, 1'b0);
            checks++; if (upd_valid !== 1'b1 || upd_index_pc !== 48'hA000 + 48'(i) || upd_correct_pc !== 48'hB000 + 48'(i) || count !== 3'(DEPTH - i)) begin
                errors++; $display("FAIL full_drain %0d valid %b idx %h cpc %h count %0d want 1 %h %h %0d", i, upd_valid, upd_index_pc, upd_correct_pc, count, 48'hA000 + 48'(i), 48'hB000 + 48'(i), DEPTH - i);
            end
        end
        drive(1'b0, 1'b0, 48'h0, 48'h0, 1'b0, 1'b0);
        checks++; if (upd_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL full_dropped valid %b count %0d want 0 0", upd_valid, count); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 48'hC000 + 48'(i), 48'hC100, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 48'h3000, 48'h3100, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 48'h0, 48'h0, 1'b1, 1'b0);
        checks++; if (count !== 3'd1 || upd_valid !== 1'b0) begin errors++; $display("FAIL flush_count count %0d valid %b want 1 0", count, upd_valid); end
        drive(1'b0, 1'b0, 48'h0, 48'h0, 1'b0, 1'b0);
        checks++; if (upd_valid !== 1'b1 || upd_index_pc !== 48'h3000 || upd_correct_pc !== 48'h3100) begin errors++; $display("FAIL flush_issue valid %b idx %h cpc %h want 1 3000 3100", upd_valid, upd_index_pc, upd_correct_pc); end
        drive(1'b1, 1'b0, 48'h7000, 48'h7100, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 48'h7777, 48'h7100, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 48'h0, 48'h0, 1'b1, 1'b0);
        checks++; if (count !== 3'd0 || upd_valid !== 1'b0) begin errors++; $display("FAIL flush_discard count %0d valid %b want 0 0", count, upd_valid); end
    endtask

    task automatic test_coalesce();
        do_reset();
        drive(1'b1, 1'b0, 48'h4000, 48'h5000, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 48'h4000, 48'h6000, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 48'h0, 48'h0, 1'b1, 1'b0);
`ifdef BP_UPD_COALESCE_EN
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL coal_count got %0d want 1", count); end
        drive(1'b0, 1'b0, 48'h0, 48'h0, 1'b0, 1'b0);
        checks++; if (upd_valid !== 1'b1 || upd_correct_pc !== 48'h6000) begin errors++; $display("FAIL coal_issue valid %b cpc %h want 1 6000", upd_valid, upd_correct_pc); end
`else
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL coal_count got %0d want 2", count); end
        drive(1'b0, 1'b0, 48'h0, 48'h0, 1'b0, 1'b0);
        checks++; if (upd_valid !== 1'b1 || upd_correct_pc !== 48'h5000) begin errors++; $display("FAIL coal_issue0 valid %b cpc %h want 1 5000", upd_valid, upd_correct_pc); end
        drive(1'b0, 1'b0, 48'h0, 48'h0, 1'b0, 1'b0);
        checks++; if (upd_valid !== 1'b1 || upd_correct_pc !== 48'h6000) begin errors++; $display("FAIL coal_issue1 valid %b cpc %h want 1 6000", upd_valid, upd_correct_pc); end
`endif
    endtask

    task automatic test_reset_mid();
        bit seen;
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 48'hE000 + 48'(i), 48'hE100, 1'b1, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            drive(1'b0, 1'b0, 48'h0, 48'h0, 1'b1, 1'b0);
            if (upd_valid === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen || count !== 3'd3 || fetch_stall !== 1'b1) begin errors++; $display("FAIL rstmid_force seen %b count %0d stall %b want 1 3 1", seen, count, fetch_stall); end
        n_reset = 1'b0;
        #1;
        checks++; if (upd_valid !== 1'b0 || fetch_stall !== 1'b0 || count !== 3'd0 || ex_ready !== 1'b1 || upd_index_pc !== 48'h0 || upd_mispred !== 1'b0) begin
            errors++; $display("FAIL rstmid_outputs valid %b stall %b count %0d ready %b idx %h m %b want 0 0 0 1 0 0", upd_valid, fetch_stall, count, ex_ready, upd_index_pc, upd_mispred);
        end
        @(negedge clk);
        n_reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 48'h0, 48'h0, 1'b0, 1'b0);
            checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL rstmid_after cycle %0d valid %b want 0", i, upd_valid); end
        end
    endtask

    task automatic test_random();
        ent_t q[$];
        ent_t e;
        int   starve;
        int   sz;
        int   frpct;
        bit   v, m, fr, fl, exp_valid, exp_ready, match;
        logic [47:0] pc, cpc;
        do_reset();
        q.delete();
        starve = 0;
        frpct = 50;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 200 == 0) frpct = (cyc % 600 == 0) ? 30 : ((cyc % 600 == 200) ? 75 : 97);
            v   = ($urandom_range(0, 99) < 55);
            m   = $urandom_range(0, 1) == 1;
            pc  = 48'h100 * 48'($urandom_range(0, 3));
            cpc = {16'h0, 32'($urandom)};
            fr  = ($urandom_range(0, 99) < frpct);
            fl  = ($urandom_range(0, 99) < 2);
            drive(v, m, pc, cpc, fr, fl);
            sz = q.size();
            exp_valid = (sz > 0) && (!fr || starve == STARVE_MAX);
            match = 1'b0;
`ifdef BP_UPD_COALESCE_EN
            if (sz > 0 && q[sz-1].idx == pc && !(sz == 1 && exp_valid)) match = 1'b1;
`endif
            exp_ready = (sz < DEPTH) || match;
            checks++; if (ex_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready cyc %0d got %b want %b", cyc, ex_ready, exp_ready); end
            checks++; if (upd_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", cyc, upd_valid, exp_valid); end
            checks++; if (fetch_stall !== (exp_valid && fr)) begin errors++; $display("FAIL rnd_stall cyc %0d got %b want %b", cyc, fetch_stall, exp_valid && fr); end
            checks++; if (count !== 3'(sz)) begin errors++; $display("FAIL rnd_count cyc %0d got %0d want %0d", cyc, count, sz); end
            if (exp_valid) begin
                checks++; if ({upd_mispred, upd_index_pc, upd_correct_pc} !== q[0]) begin
                    errors++; $display("FAIL rnd_head cyc %0d got %b %h %h want %b %h %h", cyc, upd_mispred, upd_index_pc, upd_correct_pc, q[0].m, q[0].idx, q[0].cpc);
                end
            end
            @(posedge clk);
            e.m = m; e.idx = pc; e.cpc = cpc;
            if (fl) begin
                q.delete();
                if (v && exp_ready && m) q.push_back(e);
                starve = 0;
            end else begin
                if (v && exp_ready && match) q[sz-1] = e;
                if (exp_valid) void'(q.pop_front());
                if (v && exp_ready && !match) q.push_back(e);
                if (exp_valid || sz == 0) starve = 0;
                else if (starve < STARVE_MAX) starve++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_starve();
        test_full();
        test_flush();
        test_coalesce();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
